// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage initiator for a byte-addressed data memory bus.
//            Issues word-aligned beats with byte strobes over a req/ack
//            handshake, splits word-crossing accesses into two beats,
//            extends load data and stalls the pipeline until complete.
// Options  : MISALIGN_TRAP_EN - when defined, misaligned H/W accesses raise
//            lsu_err without bus traffic instead of being split.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] endereco,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        done,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Counter only needs to reach TIMEOUT_CYC-1; the abort fires on that value.
    localparam int                 c_CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic               c_TO_EN   = (TIMEOUT_CYC > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT1 = 2'd1,
        S_BEAT2 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [1:0]          r_ofs;
    logic [2:0]          r_f3;
    logic                r_split;
    logic [3:0]          r_strb_hi;
    logic [31:0]         r_rdata1;

    logic                w_req;
    logic [3:0]          w_base;
    logic [7:0]          w_mask;
    logic                w_split;
    logic                w_illegal;
    logic                w_reject;
    logic [63:0]         w_wdbl;
    logic [63:0]         w_ld_dbl;
    logic [63:0]         w_ld_sh;
    logic [31:0]         w_ld_raw;
    logic [31:0]         w_ld_ext;
    logic                w_timeout;

    // Decode the incoming request: lane mask, split need and legality.
    always_comb begin
        w_req = cpu_valid & (MemRead | MemWrite);
        case (funct3[1:0])
            2'b00:   w_base = 4'b0001;
            2'b01:   w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
        // Lanes [3:0] go in the first beat, lanes [7:4] overflow into the second.
        w_mask    = {4'b0000, w_base} << endereco[1:0];
        // 011/111 and 110 are undefined; unsigned forms only exist for loads.
        w_illegal = (funct3[1:0] == 2'b11) | (funct3[2:1] == 2'b11) | (funct3[2] & MemWrite);
`ifdef MISALIGN_TRAP_EN
        w_split   = 1'b0;
        w_reject  = w_illegal | (funct3[0] & endereco[0]) | (funct3[1] & (|endereco[1:0]));
`else
        w_split   = |w_mask[7:4];
        w_reject  = w_illegal;
`endif
        // Rotate store data so byte 0 lands on lane a; both beats share it.
        w_wdbl    = {write_data, write_data} << {endereco[1:0], 3'b000};
    end

    // Assemble and extend the load result from the beat(s) just acknowledged.
    always_comb begin
        w_ld_dbl = (r_state == S_BEAT2) ? {mem_rdata, r_rdata1} : {32'h0, mem_rdata};
        w_ld_sh  = w_ld_dbl >> {r_ofs, 3'b000};
        w_ld_raw = w_ld_sh[31:0];
        case (r_f3)
            3'b000:  w_ld_ext = {{24{w_ld_raw[7]}}, w_ld_raw[7:0]};
            3'b001:  w_ld_ext = {{16{w_ld_raw[15]}}, w_ld_raw[15:0]};
            3'b100:  w_ld_ext = {24'h0, w_ld_raw[7:0]};
            3'b101:  w_ld_ext = {16'h0, w_ld_raw[15:0]};
            default: w_ld_ext = w_ld_raw;
        endcase
        w_timeout = c_TO_EN & ~mem_ack & (r_cnt == c_TO_LAST);
    end

    // Stall is combinational in IDLE so an accepted request costs no bubble.
    assign stall = ((r_state == S_IDLE) & w_req) | (r_state == S_BEAT1) | (r_state == S_BEAT2);

    // Main sequencer: accept, drive beats until ack or timeout, then respond.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ofs     <= 2'b00;
            r_f3      <= 3'b000;
            r_split   <= 1'b0;
            r_strb_hi <= 4'h0;
            r_rdata1  <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            done      <= 1'b0;
            lsu_err   <= 1'b0;
            read_data <= 32'h0;
        end else begin
            done      <= 1'b0;
            lsu_err   <= 1'b0;
            read_data <= 32'h0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_reject) begin
                            // Error still passes through RESP so stall drops for a cycle.
                            lsu_err <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_ofs     <= endereco[1:0];
                            r_f3      <= funct3;
                            r_split   <= w_split;
                            r_strb_hi <= MemWrite ? w_mask[7:4] : 4'h0;
                            r_cnt     <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {endereco[31:2], 2'b00};
                            mem_wstrb <= MemWrite ? w_mask[3:0] : 4'h0;
                            mem_wdata <= MemWrite ? w_wdbl[63:32] : 32'h0;
                            r_state   <= S_BEAT1;
                        end
                    end
                end
                S_BEAT1, S_BEAT2: begin
                    if (mem_ack) begin
                        if ((r_state == S_BEAT1) && r_split) begin
                            mem_addr  <= mem_addr + 32'd4;
                            mem_wstrb <= r_strb_hi;
                            r_rdata1  <= mem_rdata;
                            r_cnt     <= '0;
                            r_state   <= S_BEAT2;
                        end else begin
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= 32'h0;
                            mem_wstrb <= 4'h0;
                            mem_wdata <= 32'h0;
                            done      <= 1'b1;
                            read_data <= mem_we ? 32'h0 : w_ld_ext;
                            r_state   <= S_RESP;
                        end
                    end else if (w_timeout) begin
                        // Abandon the beat; a committed first store beat stays committed.
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_wstrb <= 4'h0;
                        mem_wdata <= 32'h0;
                        lsu_err   <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
